reset_sequencer: RTL and testbench

Staged reset release controller. After the asynchronous system reset (or a synchronous soft-reset request) it holds every downstream reset domain in reset, then releases the domains one at a time in index order. Each release waits for that domain's ready acknowledge, bounded by a timeout, before a fixed gap precedes the next release. It sits between the board-level reset/stretcher and the per-subsystem reset inputs, and signals `ready` once the whole system is up.

---
 rtl/reset_sequencer_if.sv | 32 +++
 rtl/reset_sequencer.sv | 132 +++++++++++++
 tb/tb_reset_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Reset-sequencer bundle: soft restart and per-domain acknowledges in,
// per-domain resets and status out. The master modport is the sequencer's side.
interface reset_sequencer_if #(
    parameter int STAGES = 4
);
    localparam int SW = $clog2(STAGES + 1);

    logic              soft_reset;
    logic [STAGES-1:0] stage_ack;
    logic [STAGES-1:0] reset_out;
    logic              ready;
    logic              timeout_err;
    logic [SW-1:0]     stage;

    modport master (
        input  soft_reset,
        input  stage_ack,
        output reset_out,
        output ready,
        output timeout_err,
        output stage
    );

    modport slave (
        output soft_reset,
        output stage_ack,
        input  reset_out,
        input  ready,
        input  timeout_err,
        input  stage
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: holds every domain in reset, then releases them in index
// order, waiting for each domain's acknowledge (bounded) plus a fixed gap between releases.
module reset_sequencer #(
    parameter int STAGES      = 4,
    parameter int STAGE_DELAY = 15,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset_in,
    reset_sequencer_if.master  bus
);
    localparam int SW   = $clog2(STAGES + 1);
    localparam int MAXV = (STAGE_DELAY > ACK_TIMEOUT) ? STAGE_DELAY : ACK_TIMEOUT;
    localparam int CW   = (MAXV > 0) ? $clog2(MAXV + 1) : 1;

    localparam logic [CW-1:0] DELAY_LD   = CW'(STAGE_DELAY);
    localparam logic [CW-1:0] TO_LAST    = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(STAGES - 1);
    localparam logic [SW-1:0] ALL_STAGES = SW'(STAGES);
    localparam logic [SW-1:0] STAGE_ONE  = SW'(1);

    typedef enum logic [1:0] {HOLD, WAIT_ACK, GAP, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     stage_q, stage_d;
    logic [STAGES-1:0] reset_out_q, reset_out_d;
    logic              ready_q, ready_d;
    logic              timeout_err_q, timeout_err_d;

    // One-hot decode of the current stage, used both to release and to pick its ack.
    logic [STAGES-1:0] stage_sel;
    logic              ack_sel;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_sel
            assign stage_sel[gi] = (stage_q == SW'(gi));
        end
    endgenerate

    assign ack_sel = |(bus.stage_ack & stage_sel);

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state_q       <= HOLD;
            cnt_q         <= DELAY_LD;
            stage_q       <= '0;
            reset_out_q   <= '1;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stage_q       <= stage_d;
            reset_out_q   <= reset_out_d;
            ready_q       <= ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        logic advance;
        state_d       = state_q;
        cnt_d         = cnt_q;
        stage_d       = stage_q;
        reset_out_d   = reset_out_q;
        ready_d       = ready_q;
        timeout_err_d = timeout_err_q;
        advance       = 1'b0;

        case (state_q)
            HOLD, GAP: begin
                if (state_q == HOLD) begin
                    reset_out_d = '1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    reset_out_d = reset_out_d & ~stage_sel;
                    cnt_d       = '0;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // cnt_q counts edges already waited; a timeout behaves like an ack.
                if (ack_sel) begin
                    advance = 1'b1;
                end else if (ACK_TIMEOUT != 0 && cnt_q == TO_LAST) begin
                    timeout_err_d = 1'b1;
                    advance       = 1'b1;
                end else if (ACK_TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                if (advance) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d     = RUN;
                        ready_d     = 1'b1;
                        stage_d     = ALL_STAGES;
                        reset_out_d = '0;
                    end else begin
                        state_d = GAP;
                        cnt_d   = DELAY_LD;
                        stage_d = stage_q + STAGE_ONE;
                    end
                end
            end
            RUN: begin
                reset_out_d = '0;
                ready_d     = 1'b1;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        // Soft restart wins over everything but keeps the sticky timeout flag.
        if (bus.soft_reset) begin
            state_d       = HOLD;
            cnt_d         = DELAY_LD;
            stage_d       = '0;
            reset_out_d   = '1;
            ready_d       = 1'b0;
            timeout_err_d = timeout_err_q;
        end
    end

    assign bus.reset_out   = reset_out_q;
    assign bus.ready       = ready_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.stage       = stage_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes
// (cycle + snapshot), a negedge monitor pops one per observed change and compares.
module tb_reset_sequencer;
    logic clk;
    logic reset_in;
    int   cyc = 0;

    reset_sequencer_if #(.STAGES(3)) bus ();

    reset_sequencer #(
        .STAGES      (3),
        .STAGE_DELAY (4),
        .ACK_TIMEOUT (8)
    ) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    typedef struct {
        int         cyc;
        logic [6:0] snap;   // {reset_out[2:0], ready, timeout_err, stage[1:0]}
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c, input logic [2:0] ro, input logic rdy,
                        input logic te, input logic [1:0] st);
        ev_t e;
        e.cyc  = c;
        e.snap = {ro, rdy, te, st};
        exp_q.push_back(e);
    endtask

    // Nominal release pattern relative to base edge b (edge 1 = b+1).
    task automatic push_nominal(input int b, input logic te);
        push(b + 5,  3'b110, 1'b0, te, 2'd0);
        push(b + 6,  3'b110, 1'b0, te, 2'd1);
        push(b + 11, 3'b100, 1'b0, te, 2'd1);
        push(b + 12, 3'b100, 1'b0, te, 2'd2);
        push(b + 17, 3'b000, 1'b0, te, 2'd2);
        push(b + 18, 3'b000, 1'b1, te, 2'd3);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL %s_drain: %0d expected events still pending at cyc %0d, required 0",
                     name, exp_q.size(), cyc);
            exp_q.delete();
        end
    endtask

    // Monitor: every change of the output snapshot is one transaction.
    initial begin
        logic [6:0] snap;
        logic [6:0] prev;
        bit         first;
        ev_t        e;
        first = 1'b1;
        prev  = '0;
        forever begin
            @(negedge clk);
            snap = {bus.reset_out, bus.ready, bus.timeout_err, bus.stage};
            if (first || snap != prev) begin
                first = 1'b0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_change: cyc %0d got ro=%b rdy=%b te=%b st=%0d, required no change",
                             cyc, snap[6:4], snap[3], snap[2], snap[1:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc == cyc && e.snap == snap) begin
                        n_pass++;
                        $display("ev cyc=%0d ro=%b rdy=%b te=%b st=%0d ok",
                                 cyc, snap[6:4], snap[3], snap[2], snap[1:0]);
                    end else begin
                        $display("FAIL event: got cyc %0d ro=%b rdy=%b te=%b st=%0d, required cyc %0d ro=%b rdy=%b te=%b st=%0d",
                                 cyc, snap[6:4], snap[3], snap[2], snap[1:0],
                                 e.cyc, e.snap[6:4], e.snap[3], e.snap[2], e.snap[1:0]);
                    end
                end
            end
            prev = snap;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int c;
        reset_in       = 1'b1;
        bus.soft_reset = 1'b0;
        bus.stage_ack  = 3'b111;
        push(1, 3'b111, 1'b0, 1'b0, 2'd0);      // reset state

        // Nominal sequence
        step(3);
        reset_in = 1'b0;
        b = cyc;
        push_nominal(b, 1'b0);
        drain("nominal", 40);

        // Ack timeout on stage 1
        step(2);
        reset_in      = 1'b1;
        bus.stage_ack = 3'b101;
        push(cyc, 3'b111, 1'b0, 1'b0, 2'd0);
        step(2);
        reset_in = 1'b0;
        b = cyc;
        push(b + 5,  3'b110, 1'b0, 1'b0, 2'd0);
        push(b + 6,  3'b110, 1'b0, 1'b0, 2'd1);
        push(b + 11, 3'b100, 1'b0, 1'b0, 2'd1);
        push(b + 19, 3'b100, 1'b0, 1'b1, 2'd2);
        push(b + 24, 3'b000, 1'b0, 1'b1, 2'd2);
        push(b + 25, 3'b000, 1'b1, 1'b1, 2'd3);
        drain("timeout", 45);

        // Acks dropping in RUN must change nothing
        step(1);
        bus.stage_ack = 3'b000;
        step(3);

        // Soft reset from RUN keeps timeout_err
        c = cyc;
        bus.soft_reset = 1'b1;
        bus.stage_ack  = 3'b111;
        push(c + 1, 3'b111, 1'b0, 1'b1, 2'd0);
        step(1);
        bus.soft_reset = 1'b0;
        b = cyc;
        push_nominal(b, 1'b1);
        drain("soft", 40);

        // Async reset while in GAP after stage 0
        step(2);
        c = cyc;
        bus.soft_reset = 1'b1;
        push(c + 1, 3'b111, 1'b0, 1'b1, 2'd0);
        step(1);
        bus.soft_reset = 1'b0;
        b = cyc;
        push(b + 5, 3'b110, 1'b0, 1'b1, 2'd0);
        push(b + 6, 3'b110, 1'b0, 1'b1, 2'd1);
        step(8);
        #1;
        reset_in = 1'b1;
        push(cyc, 3'b111, 1'b0, 1'b0, 2'd0);
        step(2);
        reset_in = 1'b0;
        b = cyc;
        push_nominal(b, 1'b0);
        drain("async", 40);

        // Late ack on stage 0 (sampled at edge 8)
        step(2);
        reset_in      = 1'b1;
        bus.stage_ack = 3'b110;
        push(cyc, 3'b111, 1'b0, 1'b0, 2'd0);
        step(2);
        reset_in = 1'b0;
        b = cyc;
        push(b + 5,  3'b110, 1'b0, 1'b0, 2'd0);
        push(b + 8,  3'b110, 1'b0, 1'b0, 2'd1);
        push(b + 13, 3'b100, 1'b0, 1'b0, 2'd1);
        push(b + 14, 3'b100, 1'b0, 1'b0, 2'd2);
        push(b + 19, 3'b000, 1'b0, 1'b0, 2'd2);
        push(b + 20, 3'b000, 1'b1, 1'b0, 2'd3);
        step(7);
        bus.stage_ack = 3'b111;
        drain("late_ack", 40);

        // Soft reset held high keeps reloading HOLD
        step(2);
        c = cyc;
        bus.soft_reset = 1'b1;
        push(c + 1, 3'b111, 1'b0, 1'b0, 2'd0);
        step(6);
        bus.soft_reset = 1'b0;
        b = cyc;
        push_nominal(b, 1'b0);
        drain("soft_held", 40);

        step(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
